// File: rtl/alu_mult_seq.sv
// Sequential 16x16 unsigned shift-and-add multiplier that borrows an external
// combinational ALU for its adds and shifts; keeps the low 16 product bits and flags overflow.
module alu_mult_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        ovf,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_op,
    output logic        alu_cin,
    output logic        alu_invA,
    output logic        alu_invB,
    output logic        alu_sign,
    input  logic [15:0] alu_out,
    input  logic        alu_ofl,
    input  logic        alu_zero
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] OP_SLL = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd4;

    state_t      state_q, state_d;
    logic [15:0] mcand_q, mcand_d;
    logic [15:0] mplier_q, mplier_d;
    logic [15:0] acc_q, acc_d;
    logic        ovf_q, ovf_d;
    logic [15:0] mplier_shr;
    logic        unused_alu_zero;

    assign mplier_shr      = mplier_q >> 1;
    assign unused_alu_zero = alu_zero;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= 16'd0;
            mplier_q <= 16'd0;
            acc_q    <= 16'd0;
            ovf_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next-state logic; SHIFT exits early once no multiplier bits remain
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (b != 16'd0) ? S_ADD : S_DONE;
            S_ADD:   state_d = S_SHIFT;
            S_SHIFT: state_d = (mplier_shr == 16'd0) ? S_DONE : S_ADD;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = a;
                    mplier_d = b;
                    acc_d    = 16'd0;
                    ovf_d    = 1'b0;
                end
            end
            S_ADD: begin
                if (mplier_q[0]) begin
                    acc_d = alu_out;
                    ovf_d = ovf_q | alu_ofl;
                end
            end
            S_SHIFT: begin
                mcand_d  = alu_out;
                mplier_d = mplier_shr;
                // A set MSB shifted out while multiplier bits remain means lost product bits
                ovf_d    = ovf_q | (mcand_q[15] & (mplier_shr != 16'd0));
            end
            default: begin
            end
        endcase
    end

    // Output logic
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        alu_a  = 16'd0;
        alu_b  = 16'd0;
        alu_op = OP_ADD;
        case (state_q)
            S_ADD: begin
                busy  = 1'b1;
                alu_a = acc_q;
                alu_b = mcand_q;
            end
            S_SHIFT: begin
                busy   = 1'b1;
                alu_a  = mcand_q;
                alu_b  = 16'd1;
                alu_op = OP_SLL;
            end
            S_DONE: done = 1'b1;
            default: begin
            end
        endcase
    end

    assign result   = acc_q;
    assign ovf      = ovf_q;
    assign alu_cin  = 1'b0;
    assign alu_invA = 1'b0;
    assign alu_invB = 1'b0;
    assign alu_sign = 1'b0;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Directed bench for alu_mult_seq: models the shared combinational ALU and
// checks latency, result, overflow, ALU operand sequencing and reset behaviour.
module tb_alu_mult_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        ovf;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_op;
    logic        alu_cin;
    logic        alu_invA;
    logic        alu_invB;
    logic        alu_sign;
    logic [15:0] alu_out;
    logic        alu_ofl;
    logic        alu_zero;

    int checks = 0;
    int errors = 0;

    alu_mult_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .ovf      (ovf),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_cin  (alu_cin),
        .alu_invA (alu_invA),
        .alu_invB (alu_invB),
        .alu_sign (alu_sign),
        .alu_out  (alu_out),
        .alu_ofl  (alu_ofl),
        .alu_zero (alu_zero)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU model; ofl is the unsigned carry of ADD
    always_comb begin
        logic [16:0] sum;
        sum     = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out = 16'd0;
        alu_ofl = 1'b0;
        case (alu_op)
            3'd0: alu_out = (alu_a << alu_b[3:0]) | (alu_a >> (5'd16 - {1'b0, alu_b[3:0]}));
            3'd1: alu_out = alu_a << alu_b[3:0];
            3'd2: alu_out = (alu_a >> alu_b[3:0]) | (alu_a << (5'd16 - {1'b0, alu_b[3:0]}));
            3'd3: alu_out = $unsigned($signed(alu_a) >>> alu_b[3:0]);
            3'd4: begin
                alu_out = sum[15:0];
                alu_ofl = sum[16];
            end
            3'd5: alu_out = alu_a | alu_b;
            3'd6: alu_out = alu_a ^ alu_b;
            default: alu_out = alu_a & alu_b;
        endcase
        alu_zero = (alu_out == 16'd0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one multiply from IDLE and follow it to DONE, then back into IDLE.
    // With hold set, start stays high and a/b are scrambled while the block is busy.
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                          input int exp_cyc, input logic [15:0] exp_res, input logic exp_ovf,
                          input bit hold);
        int done_cyc;
        done_cyc = 0;
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        tick();
        if (hold) begin
            a = 16'hFFFF;
            b = 16'hFFFF;
        end else begin
            start = 1'b0;
        end
        for (int c = 1; c <= 64; c++) begin
            if (done === 1'b1) begin
                done_cyc = c;
                break;
            end
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            check({tag, "_alu_op"}, {29'd0, alu_op}, (c % 2 == 1) ? 32'd4 : 32'd1);
            if (c % 2 == 0) check({tag, "_alu_b_shift"}, {16'd0, alu_b}, 32'd1);
            tick();
        end
        start = 1'b0;
        check({tag, "_done_cycle"}, done_cyc, exp_cyc);
        check({tag, "_result"}, {16'd0, result}, {16'd0, exp_res});
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
        check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_alu_a_in_done"}, {16'd0, alu_a}, 32'd0);
        tick();
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_result_held"}, {16'd0, result}, {16'd0, exp_res});
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = 16'd0;
        b     = 16'd0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", {16'd0, result}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_alu_a", {16'd0, alu_a}, 32'd0);
        check("rst_alu_b", {16'd0, alu_b}, 32'd0);
        check("rst_alu_op", {29'd0, alu_op}, 32'd4);
        check("tied_ctl", {28'd0, alu_cin, alu_invA, alu_invB, alu_sign}, 32'd0);
        tick();
        rst_n = 1'b1;
        a     = 16'h5555;
        b     = 16'h3333;
        tick();
        tick();
        check("idle_no_start_busy", {31'd0, busy}, 32'd0);
        check("idle_no_start_done", {31'd0, done}, 32'd0);
        check("idle_no_start_result", {16'd0, result}, 32'd0);

        run_op("3x5", 16'd3, 16'd5, 7, 16'd15, 1'b0, 1'b0);
        run_op("ffffx1", 16'hFFFF, 16'd1, 3, 16'hFFFF, 1'b0, 1'b0);
        run_op("100x100", 16'h0100, 16'h0100, 19, 16'h0000, 1'b1, 1'b0);
        run_op("8000x3", 16'h8000, 16'd3, 5, 16'h8000, 1'b1, 1'b0);
        run_op("1234x0", 16'h1234, 16'd0, 1, 16'd0, 1'b0, 1'b0);
        run_op("b2b_6x6", 16'd6, 16'd6, 7, 16'd36, 1'b0, 1'b0);
        run_op("hold_7x9", 16'd7, 16'd9, 9, 16'd63, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("hold_no_second_busy", {31'd0, busy}, 32'd0);
            check("hold_no_second_done", {31'd0, done}, 32'd0);
            tick();
        end
        check("hold_result_kept", {16'd0, result}, 32'd63);

        a     = 16'h00FF;
        b     = 16'h00FF;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_result", {16'd0, result}, 32'd0);
        check("async_rst_ovf", {31'd0, ovf}, 32'd0);
        check("async_rst_alu_op", {29'd0, alu_op}, 32'd4);
        check("async_rst_alu_a", {16'd0, alu_a}, 32'd0);
        tick();
        check("held_rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        run_op("post_rst_2x2", 16'd2, 16'd2, 5, 16'd4, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
